reg_dump_tx: RTL and testbench
==============================

REG_DUMP_TX -- requirements
Module: reg_dump_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, clock cycles per UART bit (115200 baud at 100 MHz); legal range 2..65535.
REQ-002 SHALL have parameter LAST_REG, default 31, highest register index dumped; legal range 0..31.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a dump; honoured only when idle.
REQ-006 SHALL have port rd_addr  output  5  register-file read address, driven to the register being dumped.
REQ-007 SHALL have port rd_data  input  32  combinational register-file read data for rd_addr.
REQ-008 SHALL have port tx  output  1  UART 8N1 serial line, idle high.
REQ-009 SHALL have port busy  output  1  high from the cycle after an accepted start until done.
REQ-010 SHALL have port done  output  1  one-cycle pulse when the dump completes.

Function
REQ-011 SHALL implement states IDLE, FETCH, START_BIT, DATA_BITS, STOP_BIT, FINISH.
REQ-012 IDLE: tx=1, busy=0, rd_addr=0; start=1 -> FETCH at next edge with reg index 0, byte index 0.
REQ-013 FETCH lasts exactly 1 cycle; SHALL latch rd_data into 32-bit shift buffer, then go to START_BIT.
REQ-014 START_BIT: tx=0 for CLKS_PER_BIT cycles -> DATA_BITS.
REQ-015 DATA_BITS: 8 bits, LSB first, each held CLKS_PER_BIT cycles; bit counter 0..7 -> STOP_BIT after bit 7.
REQ-016 STOP_BIT: tx=1 for CLKS_PER_BIT cycles; then byte index<3 -> START_BIT with next byte, no gap cycles.
REQ-017 Byte order per register SHALL be little-endian: data[7:0], [15:8], [23:16], [31:24].
REQ-018 After byte 3 stop bit: reg index<LAST_REG -> increment reg index, FETCH; reg index==LAST_REG -> FINISH.
REQ-019 FINISH lasts 1 cycle with done=1, busy=1; then IDLE.
REQ-020 Per-register time SHALL be exactly 1 + 40*CLKS_PER_BIT cycles; total dump (LAST_REG+1)*(1+40*CLKS_PER_BIT)+1 cycles after start accepted.
REQ-021 rd_addr SHALL equal the current reg index in every non-IDLE state and is stable throughout a register's four bytes.
REQ-022 start while busy SHALL be ignored, no queuing; start in the FINISH cycle also ignored.
REQ-023 Baud counter SHALL be 16 bits, count 0..CLKS_PER_BIT-1, wrap to 0 at each bit boundary.
REQ-024 Data latched in FETCH SHALL be transmitted unchanged even if register-file contents change mid-register.
REQ-025 LAST_REG=0 SHALL dump only register 0 (4 bytes) then FINISH.

Reset
REQ-026 rst_n=0 at a rising edge SHALL force IDLE, tx=1, busy=0, done=0, rd_addr=0, clear all counters and buffer.
REQ-027 Reset mid-frame SHALL abort the dump; tx returns high at that edge, no done pulse.
REQ-028 start sampled in the same cycle as rst_n=0 SHALL be ignored.

Structure
REQ-029 State encoding and UART framing constants (DATA_BITS=8, BYTES_PER_REG=4) SHALL live in a shared package reg_dump_pkg.
REQ-030 Bit-serialiser (baud counter + start/data/stop framing of one byte with ready/valid) SHALL be sub-module uart_tx_byte; reg_dump_tx sequences registers and bytes.

Verification (bench with CLKS_PER_BIT=4, UART monitor sampling mid-bit)
REQ-031 Reg file preloaded with reg9=1, reg11=3, others 0, LAST_REG=31, start pulse -> 128 bytes; byte 36=0x01, byte 44=0x03, all others 0x00; done after 32*161+1 cycles.
REQ-032 LAST_REG=0, reg0=0xDEADBEEF -> bytes EF BE AD DE, tx low exactly 4 cycles per start bit, done at cycle 162.
REQ-033 start re-pulsed at cycles 10 and 100 during dump -> byte stream and done timing identical to REQ-031.
REQ-034 rst_n=0 during byte 2 of reg 5 -> tx=1 next edge, busy=0, no done; later start -> full dump from reg 0.
REQ-035 Reg 3 rewritten 0x12345678->0 during its byte 1 -> bytes 78 56 34 12 transmitted for reg 3.
REQ-036 Two back-to-back starts, second on cycle after done -> second dump accepted, tx never low between frames outside start/data bits.

Source files
------------

// File: rtl/reg_dump_pkg.sv
// Shared constants for the register-dump UART transmitter:
// FSM state encoding and 8N1 framing sizes.
package reg_dump_pkg;

    localparam int DATA_BITS     = 8;
    localparam int BYTES_PER_REG = 4;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_FETCH     = 3'd1;
    localparam logic [2:0] ST_START_BIT = 3'd2;
    localparam logic [2:0] ST_DATA_BITS = 3'd3;
    localparam logic [2:0] ST_STOP_BIT  = 3'd4;
    localparam logic [2:0] ST_FINISH    = 3'd5;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser with baud counter and valid/ready intake.
// A new byte is taken in the last stop-bit cycle, so frames are gapless.
module uart_tx_byte
    import reg_dump_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       valid,
    input  logic [7:0] data,
    output logic       ready,
    output logic       tx,
    output logic [2:0] phase
);

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [2:0]  BIT_LAST  = 3'(DATA_BITS - 1);

    logic [15:0] baud;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;
    logic        bit_end;

    assign bit_end = (baud == BAUD_LAST);
    assign ready   = (phase == ST_IDLE) ||
                     (phase == ST_STOP_BIT && bit_end);

    always_comb begin
        tx = 1'b1;
        unique case (1'b1)
            phase == ST_START_BIT: tx = 1'b0;
            phase == ST_DATA_BITS: tx = shreg[0];
            default:               tx = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase   <= ST_IDLE;
            baud    <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            baud <= (phase == ST_IDLE || bit_end) ? '0 : baud + 16'd1;
            if (ready && valid) begin
                phase   <= ST_START_BIT;
                shreg   <= data;
                bit_idx <= '0;
            end else if (bit_end) begin
                case (phase)
                    ST_START_BIT: phase <= ST_DATA_BITS;
                    ST_DATA_BITS: begin
                        shreg <= shreg >> 1;
                        if (bit_idx == BIT_LAST) begin
                            phase <= ST_STOP_BIT;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                    default: phase <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/reg_dump_tx.sv
// Dumps register file entries 0..LAST_REG over UART, four bytes each,
// little-endian, then pulses done.
module reg_dump_tx
    import reg_dump_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int LAST_REG     = 31
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [4:0]  rd_addr,
    input  logic [31:0] rd_data,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam logic [4:0] REG_LAST  = 5'(LAST_REG);
    localparam logic [1:0] BYTE_LAST = 2'(BYTES_PER_REG - 1);

    logic [2:0]  ctl;
    logic [2:0]  phase;
    logic [2:0]  state;
    logic [4:0]  reg_idx;
    logic [1:0]  byte_idx;
    logic [1:0]  nxt_idx;
    logic [31:0] buffer;
    logic        ser_valid;
    logic        ser_ready;
    logic [7:0]  ser_data;

    // ctl parks in ST_START_BIT for a whole register; the serialiser
    // supplies the start/data/stop sub-state.
    assign state = (ctl == ST_START_BIT) ? phase : ctl;

    assign nxt_idx   = byte_idx + 2'd1;
    assign ser_valid = (ctl == ST_FETCH) ||
                       (ctl == ST_START_BIT && byte_idx != BYTE_LAST);
    assign ser_data  = (ctl == ST_FETCH) ? rd_data[7:0]
                                         : buffer[{nxt_idx, 3'b000} +: 8];

    assign rd_addr = reg_idx;
    assign busy    = (state != ST_IDLE);
    assign done    = (state == ST_FINISH);

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_ser (
        .clk  (clk),
        .rst_n(rst_n),
        .valid(ser_valid),
        .data (ser_data),
        .ready(ser_ready),
        .tx   (tx),
        .phase(phase)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctl      <= ST_IDLE;
            reg_idx  <= '0;
            byte_idx <= '0;
            buffer   <= '0;
        end else begin
            case (ctl)
                ST_IDLE: begin
                    if (start) begin
                        ctl      <= ST_FETCH;
                        reg_idx  <= '0;
                        byte_idx <= '0;
                    end
                end
                ST_FETCH: begin
                    buffer <= rd_data;
                    ctl    <= ST_START_BIT;
                end
                ST_START_BIT: begin
                    if (ser_ready) begin
                        if (byte_idx != BYTE_LAST) begin
                            byte_idx <= nxt_idx;
                        end else if (reg_idx == REG_LAST) begin
                            ctl <= ST_FINISH;
                        end else begin
                            reg_idx  <= reg_idx + 5'd1;
                            byte_idx <= '0;
                            ctl      <= ST_FETCH;
                        end
                    end
                end
                ST_FINISH: begin
                    ctl      <= ST_IDLE;
                    reg_idx  <= '0;
                    byte_idx <= '0;
                end
                default: ctl <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_dump_tx.sv
// Directed bench for reg_dump_tx: UART monitor sampling mid-bit,
// byte scoreboard, done timing, restart, reset abort, LAST_REG=0.
module tb_reg_dump_tx;

    localparam int C     = 4;
    localparam int PER   = 1 + 40 * C;
    localparam int EXP31 = 32 * PER;
    localparam int EXP0  = PER;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        start0;
    logic [4:0]  rd_addr;
    logic [4:0]  rd_addr0;
    logic [31:0] rd_data;
    logic [31:0] rd_data0;
    logic        tx;
    logic        tx0;
    logic        busy;
    logic        busy0;
    logic        done;
    logic        done0;

    logic [31:0] rf [32];
    logic [7:0]  qa [$];
    logic [7:0]  qb [$];

    int          n_cmp;
    int          n_err;
    int          m_busy [2];
    int          m_cnt [2];
    int          rx_cnt [2];
    logic [7:0]  m_byte [2];

    always #5 clk = ~clk;

    assign rd_data  = rf[rd_addr];
    assign rd_data0 = (rd_addr0 == 5'd0) ? 32'hDEADBEEF : 32'h0;

    reg_dump_tx #(
        .CLKS_PER_BIT(C),
        .LAST_REG    (31)
    ) u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .tx     (tx),
        .busy   (busy),
        .done   (done)
    );

    reg_dump_tx #(
        .CLKS_PER_BIT(C),
        .LAST_REG    (0)
    ) u_dut0 (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start0),
        .rd_addr(rd_addr0),
        .rd_data(rd_data0),
        .tx     (tx0),
        .busy   (busy0),
        .done   (done0)
    );

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic mon_step(input int i, input logic t);
        logic [7:0] e;
        bit         have;
        if (!rst_n) begin
            m_busy[i] = 0;
        end else if (m_busy[i] == 0) begin
            if (t === 1'b0) begin
                m_busy[i] = 1;
                m_cnt[i]  = 0;
            end
        end else begin
            m_cnt[i]++;
            if (m_cnt[i] == 3) begin
                chk("start_bit_low", {31'd0, t}, 32'd0);
            end else if (m_cnt[i] >= 6 && m_cnt[i] <= 34 &&
                         (m_cnt[i] - 2) % 4 == 0) begin
                m_byte[i][(m_cnt[i] - 6) / 4] = t;
            end else if (m_cnt[i] == 38) begin
                chk("stop_bit_high", {31'd0, t}, 32'd1);
                have = (i == 0) ? (qa.size() != 0) : (qb.size() != 0);
                chk("rx_expected_pending", {31'd0, have}, 32'd1);
                if (have) begin
                    e = (i == 0) ? qa.pop_front() : qb.pop_front();
                    chk("rx_byte", {24'd0, m_byte[i]}, {24'd0, e});
                end
                rx_cnt[i]++;
                m_busy[i] = 0;
            end
        end
    endtask

    always @(posedge clk) begin
        #1;
        mon_step(0, tx);
        mon_step(1, tx0);
    end

    task automatic push_all();
        for (int r = 0; r < 32; r++) begin
            for (int b = 0; b < 4; b++) begin
                qa.push_back(rf[r][8*b +: 8]);
            end
        end
    endtask

    task automatic run_dump(input int ra, input int rb,
                            input bit fpoke, input bit cin,
                            input bit cout, input int poke_n);
        int n;
        bit seen;
        if (!cin) @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n    = 0;
        seen = 0;
        while (!seen && n < EXP31 + 64) begin
            @(posedge clk);
            #1 n++;
            start = (n == ra || n == rb);
            if (n == poke_n) rf[3] = 32'h0;
            if (n == 1) chk("busy_fetch", {31'd0, busy}, 32'd1);
            if (n % PER == 100) chk("rd_addr", {27'd0, rd_addr}, 32'(n / PER));
            if (done) seen = 1;
        end
        chk("done_cycle", n, EXP31);
        chk("busy_in_finish", {31'd0, busy}, 32'd1);
        if (cout) begin
            @(posedge clk);
            #1 chk("idle_between", {31'd0, busy}, 32'd0);
        end else begin
            start = fpoke;
            @(posedge clk);
            #1 start = 1'b0;
            chk("done_pulse_end", {31'd0, done}, 32'd0);
            chk("busy_after", {31'd0, busy}, 32'd0);
            @(posedge clk);
            #1 chk("no_restart", {31'd0, busy}, 32'd0);
        end
    endtask

    initial begin
        int n;
        int rx0;
        bit seen;
        rst_n  = 1'b0;
        start  = 1'b0;
        start0 = 1'b0;
        for (int i = 0; i < 32; i++) rf[i] = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx", {31'd0, tx}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_rd_addr", {27'd0, rd_addr}, 32'd0);
        chk("rst_tx0", {31'd0, tx0}, 32'd1);
        @(negedge clk) rst_n = 1'b1;

        // full dump, sparse register file
        rf[9]  = 32'h1;
        rf[11] = 32'h3;
        push_all();
        run_dump(0, 0, 1'b0, 1'b0, 1'b0, -1);
        chk("drain_a", qa.size(), 0);

        // restarts during the dump and in the FINISH cycle are ignored
        push_all();
        run_dump(10, 100, 1'b1, 1'b0, 1'b0, -1);
        chk("drain_b", qa.size(), 0);

        // reg 3 overwritten mid-register, then back-to-back dump
        rf[3] = 32'h12345678;
        push_all();
        run_dump(0, 0, 1'b0, 1'b0, 1'b1, 3 * PER + 1 + 40 + 20);
        push_all();
        run_dump(0, 0, 1'b0, 1'b1, 1'b0, -1);
        chk("drain_cd", qa.size(), 0);

        // reset during byte 2 of reg 5, with start held at the reset edge
        push_all();
        rx0 = rx_cnt[0];
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (906) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_tx", {31'd0, tx}, 32'd1);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_rd_addr", {27'd0, rd_addr}, 32'd0);
        chk("bytes_before_abort", rx_cnt[0] - rx0, 22);
        qa.delete();
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
        seen  = 0;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk);
            #1 if (done || busy) seen = 1;
        end
        chk("quiet_after_abort", {31'd0, seen}, 32'd0);

        push_all();
        run_dump(0, 0, 1'b0, 1'b0, 1'b0, -1);
        chk("drain_f", qa.size(), 0);

        // single-register dump
        qb.push_back(8'hEF);
        qb.push_back(8'hBE);
        qb.push_back(8'hAD);
        qb.push_back(8'hDE);
        @(negedge clk) start0 = 1'b1;
        @(posedge clk);
        #1 start0 = 1'b0;
        n    = 0;
        seen = 0;
        while (!seen && n < EXP0 + 100) begin
            @(posedge clk);
            #1 n++;
            if (n == 80) chk("rd_addr0", {27'd0, rd_addr0}, 32'd0);
            if (done0) seen = 1;
        end
        chk("done0_cycle", n, EXP0);
        @(posedge clk);
        #1;
        chk("done0_end", {31'd0, done0}, 32'd0);
        chk("busy0_end", {31'd0, busy0}, 32'd0);
        chk("drain_g", qb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
